// File: rtl/alu_op_driver.sv
// alu_op_driver: queues ALU requests, issues them one at a time to an external
// ALU, waits a fixed latency, and presents the captured result as a response.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high. req_ready depends only on queue occupancy, never on req_valid.
// Once rsp_valid is high, the rsp_* payload is held stable until the transfer.
module alu_op_driver #(
    parameter int FIFO_DEPTH  = 4,
    parameter int ALU_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic [31:0] alu_inp1,
    output logic [31:0] alu_inp2,
    output logic [3:0]  alu_operation,
    input  logic [31:0] alu_out,
    input  logic        alu_carryFlag,
    input  logic        alu_zeroFlag,
    input  logic        alu_signFlag,
    input  logic        alu_c32,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic [3:0]  rsp_flags,
    output logic        rsp_err,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int LW = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [LW-1:0]   cnt_q, cnt_d;

    // Request queue: each entry is {op, a, b}.
    logic [67:0]     mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;

    logic            full, empty, push, pop;
    logic            load_alu, capture, reserve;
    logic [67:0]     head;
    logic [3:0]      head_op;

    logic [31:0]     alu_inp1_q, alu_inp2_q;
    logic [3:0]      alu_op_q;
    logic [31:0]     rsp_result_q;
    logic [3:0]      rsp_flags_q;
    logic            rsp_err_q;

    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign push    = req_valid && !full;
    assign head    = mem_q[rd_ptr_q];
    assign head_op = head[67:64];

    // Queue storage: data only, no reset needed since occupancy gates reads.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {req_op, req_a, req_b};
        end
    end

    // Queue pointers and occupancy; pointers wrap naturally at a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // FSM state and latency counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic plus the one-cycle strobes that steer the datapath.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pop      = 1'b0;
        load_alu = 1'b0;
        capture  = 1'b0;
        reserve  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (head_op > 4'd8) begin
                        // Reserved opcode: never reaches the ALU.
                        reserve = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        load_alu = 1'b1;
                        cnt_d    = '0;
                        state_d  = S_ISSUE;
                    end
                end
            end
            S_ISSUE, S_WAIT: begin
                if (cnt_q == LW'(ALU_LATENCY - 1)) begin
                    capture = 1'b1;
                    cnt_d   = '0;
                    state_d = S_RESP;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Operand registers toward the ALU, held for the whole issue window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_inp1_q <= '0;
            alu_inp2_q <= '0;
            alu_op_q   <= '0;
        end else if (load_alu) begin
            alu_op_q   <= head_op;
            alu_inp1_q <= head[63:32];
            alu_inp2_q <= head[31:0];
        end
    end

    // Response registers: loaded on the last latency cycle or on a reserved op.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            rsp_err_q    <= 1'b0;
        end else if (capture) begin
            rsp_result_q <= alu_out;
            rsp_flags_q  <= {alu_c32, alu_signFlag, alu_zeroFlag, alu_carryFlag};
            rsp_err_q    <= 1'b0;
        end else if (reserve) begin
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            rsp_err_q    <= 1'b1;
        end
    end

    assign req_ready     = !full;
    assign rsp_valid     = (state_q == S_RESP);
    assign busy          = (state_q != S_IDLE) || !empty;
    assign alu_inp1      = alu_inp1_q;
    assign alu_inp2      = alu_inp2_q;
    assign alu_operation = alu_op_q;
    assign rsp_result    = rsp_result_q;
    assign rsp_flags     = rsp_flags_q;
    assign rsp_err       = rsp_err_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_alu_op_driver.sv
// Testbench for alu_op_driver with a behavioural ALU attached and a response
// scoreboard fed by a reference model of the request semantics.
`timescale 1ns/1ps
module tb_alu_op_driver;

    localparam int DEPTH = 4;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_a, req_b;
    logic [31:0] alu_inp1, alu_inp2;
    logic [3:0]  alu_operation;
    logic [31:0] alu_out;
    logic        alu_carryFlag, alu_zeroFlag, alu_signFlag, alu_c32;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic        rsp_err;
    logic        busy;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    // Expected responses, each {err, flags[3:0], result[31:0]}.
    logic [36:0] exp_q[$];

    // Clock
    always #5 clk = ~clk;

    alu_op_driver #(.FIFO_DEPTH(DEPTH), .ALU_LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .alu_inp1(alu_inp1), .alu_inp2(alu_inp2), .alu_operation(alu_operation),
        .alu_out(alu_out), .alu_carryFlag(alu_carryFlag), .alu_zeroFlag(alu_zeroFlag),
        .alu_signFlag(alu_signFlag), .alu_c32(alu_c32),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
        .busy(busy), .dbg_state(dbg_state)
    );

    // Behavioural ALU function: returns {c32, sign, zero, carry, result}.
    function automatic logic [35:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [32:0] s;
        logic [31:0] r;
        logic        c, c32, z;
        s = '0; r = '0; c = 1'b0; c32 = 1'b0;
        case (op)
            4'd0: begin
                s   = {1'b0, a} + {1'b0, b};
                r   = s[31:0];
                c   = s[32];
                c32 = a[31] ^ b[31] ^ r[31];
            end
            4'd1: r = a & b;
            4'd2: r = a ^ b;
            4'd3: r = 32'd0 - a;
            4'd4: r = a << b[4:0];
            4'd5: r = a >> b[4:0];
            4'd6: r = $signed(a) >>> b[4:0];
            4'd7: r = {31'd0, a[31]};
            4'd8: r = {31'd0, (a == 32'd0)};
            default: r = '0;
        endcase
        z = (op == 4'd8) ? (a == 32'd0) : (r == 32'd0);
        return {c32, r[31], z, c, r};
    endfunction

    // Reference model of one request's response.
    function automatic logic [36:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        if (op > 4'd8) return {1'b1, 36'd0};
        return {1'b0, alu_fn(op, a, b)};
    endfunction

    // The external ALU: result valid one registered stage after operands change,
    // so only a driver that honours LAT=2 samples a settled value.
    logic [35:0] alu_q = '0;
    always @(posedge clk) alu_q <= alu_fn(alu_operation, alu_inp1, alu_inp2);
    assign {alu_c32, alu_signFlag, alu_zeroFlag, alu_carryFlag, alu_out} = alu_q;

    // Scoreboard: checks every completed response and payload stability while held.
    logic        prev_hold = 1'b0;
    logic [36:0] prev_val, got_val, want_val;
    always @(negedge clk) begin
        got_val = {rsp_err, rsp_flags, rsp_result};
        if (reset) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold && rsp_valid) begin
                n_checks++;
                if (got_val !== prev_val)
                    $display("FAIL rsp_stable got=%h exp=%h", got_val, prev_val);
                else n_pass++;
            end
            if (rsp_valid && rsp_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_rsp got=%h exp=none", got_val);
                end else begin
                    want_val = exp_q.pop_front();
                    if (got_val !== want_val)
                        $display("FAIL rsp_data got=%h exp=%h", got_val, want_val);
                    else n_pass++;
                end
            end
            prev_hold = rsp_valid && !rsp_ready;
            prev_val  = got_val;
        end
    end

    // Driver: present one request until accepted; caller is #1 after a posedge.
    task automatic push_req(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int  waitc;
        logic acc;
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        acc = 1'b0; waitc = 0;
        while (!acc && waitc < 200) begin
            @(negedge clk); acc = req_ready;
            @(posedge clk); #1;
            waitc++;
        end
        req_valid = 1'b0;
        if (acc) exp_q.push_back(model(op, a, b));
        else begin
            n_checks++;
            $display("FAIL push_timeout op=%h got=not_accepted exp=accepted", op);
        end
    endtask

    task automatic wait_valid(input string name);
        int c;
        c = 0;
        while (!rsp_valid && c < 100) begin @(posedge clk); #1; c++; end
        if (!rsp_valid) begin
            n_checks++;
            $display("FAIL %s_valid_timeout got=0 exp=1", name);
        end
    endtask

    task automatic pulse_ready();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic drain(input string name);
        int c;
        c = 0;
        rsp_ready = 1'b1;
        while ((exp_q.size() != 0 || busy) && c < 1000) begin @(posedge clk); #1; c++; end
        rsp_ready = 1'b0;
        n_checks++;
        if (exp_q.size() != 0 || busy)
            $display("FAIL %s_drain got=pending%0d exp=0", name, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({req_ready, rsp_valid, rsp_err, busy} !== 4'b1000)
            $display("FAIL reset_ctrl got=%b exp=1000", {req_ready, rsp_valid, rsp_err, busy});
        else n_pass++;
        n_checks++;
        if ({rsp_result, rsp_flags} !== 36'd0)
            $display("FAIL reset_rsp got=%h exp=0", {rsp_result, rsp_flags});
        else n_pass++;
        n_checks++;
        if ({alu_inp1, alu_inp2, alu_operation} !== 68'd0)
            $display("FAIL reset_alu got=%h exp=0", {alu_inp1, alu_inp2, alu_operation});
        else n_pass++;
    endtask

    // Release reset with a request already waiting; it must go in on the first edge.
    task automatic test_add_latency();
        req_valid = 1'b1; req_op = 4'd0; req_a = 32'hFFFF_FFFF; req_b = 32'd1;
        reset = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b1) $display("FAIL first_accept got=%b exp=1", busy);
        else begin n_pass++; exp_q.push_back(model(4'd0, 32'hFFFF_FFFF, 32'd1)); end
        for (int i = 1; i <= LAT; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (rsp_valid !== 1'b0) $display("FAIL latency_early edge=%0d got=1 exp=0", i);
            else n_pass++;
        end
        @(posedge clk); #1;
        n_checks++;
        if (rsp_valid !== 1'b1) $display("FAIL latency_due got=0 exp=1");
        else n_pass++;
        n_checks++;
        if ({rsp_err, rsp_result, rsp_flags[2:0]} !== {1'b0, 32'd0, 3'b011})
            $display("FAIL add_wrap got=%h exp=%h", {rsp_err, rsp_result, rsp_flags[2:0]},
                     {1'b0, 32'd0, 3'b011});
        else n_pass++;
        pulse_ready();
        drain("add");
    endtask

    task automatic test_burst();
        logic [31:0] burst_exp[5];
        burst_exp = '{32'd104, 32'd7, 32'd210, 32'd26, 32'd479};
        rsp_ready = 1'b0;
        push_req(4'd1, 32'd105, 32'd110);
        push_req(4'd2, 32'd105, 32'd110);
        push_req(4'd4, 32'd105, 32'd1);
        push_req(4'd6, 32'd105, 32'd2);
        push_req(4'd0, 32'd42,  32'd437);
        n_checks++;
        if ({req_ready, busy, rsp_valid} !== 3'b011)
            $display("FAIL burst_full got=%b exp=011", {req_ready, busy, rsp_valid});
        else n_pass++;
        req_valid = 1'b1; req_op = 4'd2; req_a = 32'd1; req_b = 32'd1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (req_ready !== 1'b0) $display("FAIL burst_hold got=1 exp=0");
            else n_pass++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wait_valid("burst");
            n_checks++;
            if (rsp_result !== burst_exp[i])
                $display("FAIL burst_order idx=%0d got=%0d exp=%0d", i, rsp_result, burst_exp[i]);
            else n_pass++;
            pulse_ready();
        end
        drain("burst");
    endtask

    task automatic test_reserved();
        logic [67:0] saved;
        rsp_ready = 1'b0;
        saved = {alu_inp1, alu_inp2, alu_operation};
        push_req(4'b1010, 32'd5, 32'd0);
        wait_valid("reserved");
        n_checks++;
        if ({rsp_err, rsp_result, rsp_flags} !== {1'b1, 36'd0})
            $display("FAIL reserved_rsp got=%h exp=%h", {rsp_err, rsp_result, rsp_flags},
                     {1'b1, 36'd0});
        else n_pass++;
        n_checks++;
        if ({alu_inp1, alu_inp2, alu_operation} !== saved)
            $display("FAIL reserved_alu got=%h exp=%h", {alu_inp1, alu_inp2, alu_operation}, saved);
        else n_pass++;
        pulse_ready();
        drain("reserved");
    endtask

    task automatic test_eqz();
        rsp_ready = 1'b0;
        push_req(4'd8, 32'd0, 32'd0);
        push_req(4'd8, 32'd105, 32'd0);
        wait_valid("eqz0");
        n_checks++;
        if (rsp_flags[1] !== 1'b1) $display("FAIL eqz_first got=%b exp=1", rsp_flags[1]);
        else n_pass++;
        pulse_ready();
        wait_valid("eqz1");
        n_checks++;
        if (rsp_flags[1] !== 1'b0) $display("FAIL eqz_second got=%b exp=0", rsp_flags[1]);
        else n_pass++;
        pulse_ready();
        drain("eqz");
    endtask

    // Two queued, pop r2 and push r4 on the same edge, then prove occupancy by filling.
    task automatic test_push_pop();
        rsp_ready = 1'b0;
        push_req(4'd0, 32'd1, 32'd2);
        push_req(4'd1, 32'hF0F0_F0F0, 32'hFF00_FF00);
        push_req(4'd2, 32'h1234_5678, 32'h0F0F_0F0F);
        wait_valid("pushpop");
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        push_req(4'd3, 32'd7, 32'd0);
        push_req(4'd5, 32'h8000_0000, 32'd4);
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) $display("FAIL pushpop_three got=0 exp=1");
        else n_pass++;
        @(posedge clk); #1;
        push_req(4'd7, 32'h8000_0001, 32'd0);
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b0) $display("FAIL pushpop_four got=1 exp=0");
        else n_pass++;
        @(posedge clk); #1;
        drain("pushpop");
    endtask

    task automatic test_random();
        bit done;
        done = 1'b0;
        fork
            begin
                for (int n = 0; n < 40; n++) begin
                    int g;
                    g = $urandom_range(0, 2);
                    repeat (g) begin @(posedge clk); #1; end
                    push_req(4'($urandom_range(0, 15)), $urandom, $urandom);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    rsp_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        drain("random");
    endtask

    task automatic test_reset_mid();
        bit seen;
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_req(4'd0, $urandom, $urandom);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++;
        if ({busy, rsp_valid, req_ready} !== 3'b101)
            $display("FAIL mid_wait_setup got=%b exp=101", {busy, rsp_valid, req_ready});
        else n_pass++;
        reset = 1'b1;
        #1;
        exp_q.delete();
        n_checks++;
        if ({req_ready, rsp_valid, rsp_err, busy} !== 4'b1000)
            $display("FAIL mid_reset_ctrl got=%b exp=1000", {req_ready, rsp_valid, rsp_err, busy});
        else n_pass++;
        n_checks++;
        if ({rsp_result, rsp_flags, alu_inp1, alu_inp2, alu_operation} !== 104'd0)
            $display("FAIL mid_reset_data got=%h exp=0",
                     {rsp_result, rsp_flags, alu_inp1, alu_inp2, alu_operation});
        else n_pass++;
        @(posedge clk); #1;
        reset = 1'b0;
        rsp_ready = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (rsp_valid || busy) seen = 1'b1;
        end
        n_checks++;
        if (seen) $display("FAIL mid_reset_ghost got=activity exp=none");
        else n_pass++;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        push_req(4'd2, 32'hAAAA_5555, 32'hFFFF_0000);
        drain("post_reset");
    endtask

    initial begin
        test_reset();
        test_add_latency();
        test_burst();
        test_reserved();
        test_eqz();
        test_push_pop();
        test_random();
        test_reset_mid();
        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_op_driver.md
ALU_OP_DRIVER -- requirements
Module: alu_op_driver

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, request queue entries (power of two, >=2).
REQ-002 Parameter ALU_LATENCY, default 1, cycles from operand issue to valid ALU out/flags (>=1).
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  request present; req_ready  output  1  queue can accept.
REQ-006 req_op  input  4  ALU operation code; req_a, req_b  input  32  operands.
REQ-007 alu_inp1, alu_inp2  output  32  operands to ALU; alu_operation  output  4  opcode to ALU.
REQ-008 alu_out  input  32  ALU result; alu_carryFlag, alu_zeroFlag, alu_signFlag, alu_c32  input  1  ALU flags.
REQ-009 rsp_valid  output  1  response present; rsp_ready  input  1  consumer accepts.
REQ-010 rsp_result  output  32  captured result; rsp_flags  output  4  {c32, sign, zero, carry}; rsp_err  output  1  reserved opcode.
REQ-011 busy  output  1  high when FSM not IDLE or queue non-empty.

Function
REQ-012 Request accepted on rising edge with req_valid && req_ready; req_ready = !full, independent of req_valid.
REQ-013 Queue FIFO order, FIFO_DEPTH entries of {op, a, b}; pointers wrap modulo FIFO_DEPTH.
REQ-014 Push and pop in same cycle: both performed, occupancy unchanged; push when full impossible (req_ready low).
REQ-015 FSM states IDLE, ISSUE, WAIT, RESP.
REQ-016 IDLE: queue non-empty -> pop head, load alu_inp1/alu_inp2/alu_operation registers, go ISSUE; empty -> stay.
REQ-017 Valid opcodes 0000 add, 0001 and, 0010 xor, 0011 2s complement, 0100 shift left, 0101 shift right logical, 0110 shift right arithmetic, 0111 less-than-zero, 1000 equal-zero.
REQ-018 Popped opcode 1001-1111: ALU outputs unchanged, go RESP with rsp_err=1, rsp_result=0, rsp_flags=0.
REQ-019 ISSUE/WAIT: operand outputs held stable; counter counts ALU_LATENCY cycles from entering ISSUE; on final cycle sample alu_out and flags into rsp registers, go RESP.
REQ-020 With ALU_LATENCY=1 and empty idle block: request accepted at edge k -> rsp_valid high after edge k+2.
REQ-021 RESP: rsp_valid=1, rsp_result/rsp_flags/rsp_err held stable until rsp_valid && rsp_ready edge; then IDLE (next pop earliest one cycle later).
REQ-022 rsp_ready low indefinitely: hold RESP, queue continues accepting until full.
REQ-023 Operands and opcode passed to ALU unmodified, 32-bit, no sign or width conversion.
REQ-024 rsp_err=0 for every valid opcode.

Reset
REQ-025 reset asserted: immediately, without clk edge, FSM=IDLE, queue empty, counter=0.
REQ-026 Reset values: req_ready=1, rsp_valid=0, rsp_err=0, rsp_result=0, rsp_flags=0, alu_inp1=0, alu_inp2=0, alu_operation=0000, busy=0.
REQ-027 Reset mid-operation discards queued and in-flight requests; no response produced for them after release.
REQ-028 First request accepted on first rising edge after reset deasserted.

Verification
REQ-029 add: a=FFFFFFFF, b=00000001, op=0000, behavioural ALU -> rsp_result=0, carry=1, zero=1, sign=0, rsp_err=0, rsp_valid after edge k+2.
REQ-030 Burst: 5 back-to-back requests (and 105&110, xor 105^110, shl 105<<1, shra 105>>2, add 42+437), rsp_ready=0 -> req_ready low after 4 accepts while FSM holds first; release -> results 104, 7, 210, 26, 479 in order.
REQ-031 Reserved op 1010, a=5 -> rsp_err=1, result=0, flags=0, alu_operation unchanged.
REQ-032 equal-zero: a=0 then a=105, op=1000 -> zero flag 1 then 0 captured in order.
REQ-033 Reset asserted mid-WAIT with 3 queued entries -> all outputs at reset values same cycle, no rsp_valid after release until new request.
REQ-034 Simultaneous push/pop at 2 entries occupied -> occupancy stays 2, order preserved.
